// File: rtl/phy_lane_table_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// NetTypes: shared sizing constants and FSM state type for the physical-lane
// table sequencer.
//   NUM_SL3_LANES  default number of SL3 lanes
//   CONN_ID_WIDTH  default connection ID width
//   LANE_ID_WIDTH  default lane index / order / count width
//   phy_cfg_state_t sequencer FSM states
// -----------------------------------------------------------------------------
package NetTypes;

   localparam int NUM_SL3_LANES = 4;
   localparam int CONN_ID_WIDTH = 2;
   localparam int LANE_ID_WIDTH = 2;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      CHECK,
      PROGRAM,
      READY,
      ERROR
   } phy_cfg_state_t;

endpackage

// File: rtl/phy_lane_table_sequencer_if.sv
// -----------------------------------------------------------------------------
// Lane-assignment configuration port between the host register file (master)
// and the lane-table sequencer (slave).
//   cfg_valid    write request for one lane entry
//   cfg_lane     lane index being written
//   cfg_conn_id  connection assigned to that lane
//   cfg_lane_en  lane is used (1) or unused (0)
//   cfg_commit   start a table computation (single-cycle request)
//   cfg_ready    writes and commit are accepted this cycle
//   cfg_error    last commit was rejected; sticky until next accepted commit
// -----------------------------------------------------------------------------
interface phy_lane_table_sequencer_if
   import NetTypes::*;
#(
   parameter int CONN_ID_W = CONN_ID_WIDTH,
   parameter int LANE_ID_W = LANE_ID_WIDTH
);

   logic                 cfg_valid;
   logic [LANE_ID_W-1:0] cfg_lane;
   logic [CONN_ID_W-1:0] cfg_conn_id;
   logic                 cfg_lane_en;
   logic                 cfg_commit;
   logic                 cfg_ready;
   logic                 cfg_error;

   modport master (
      output cfg_valid, cfg_lane, cfg_conn_id, cfg_lane_en, cfg_commit,
      input  cfg_ready, cfg_error
   );

   modport slave (
      input  cfg_valid, cfg_lane, cfg_conn_id, cfg_lane_en, cfg_commit,
      output cfg_ready, cfg_error
   );

endinterface

// File: rtl/phy_lane_table_sequencer.sv
// -----------------------------------------------------------------------------
// phy_lane_table_sequencer
// Holds shadow lane->connection assignments written over the cfg port. On
// commit it scans the lanes one per cycle to derive per-lane order IDs,
// per-connection lane counts and the highest used connection ID, then pulses
// physical_layer_program_en for one cycle and raises router_ready.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   cfg (slave)                 lane write / commit handshake, ready, error
//   lanes_connection_id         per-lane connection ID (all-ones = unused)
//   lanes_order_id              lane's rank within its connection
//   physical_lane_list_count    lanes in this lane's connection, minus one
//   num_connections_minus_one   highest used connection ID
//   physical_layer_program_en   one-cycle table load strobe
//   router_ready                table valid, physical layer may start
//
// Build option: define PHY_LANE_CFG_CHECK_EN to reject empty tables and
// non-contiguous connection IDs (ERROR state, cfg_error). Without it the
// check always passes and cfg_error is tied 0. Latency is identical.
// -----------------------------------------------------------------------------
module phy_lane_table_sequencer
   import NetTypes::*;
#(
   parameter int NUM_LANES = NUM_SL3_LANES,
   parameter int CONN_ID_W = CONN_ID_WIDTH,
   parameter int LANE_ID_W = LANE_ID_WIDTH
)
(
   input  logic                                  clk,
   input  logic                                  rst,
   phy_lane_table_sequencer_if.slave             cfg,
   output logic [NUM_LANES-1:0][CONN_ID_W-1:0]   lanes_connection_id,
   output logic [NUM_LANES-1:0][LANE_ID_W-1:0]   lanes_order_id,
   output logic [NUM_LANES-1:0][LANE_ID_W-1:0]   physical_lane_list_count,
   output logic [LANE_ID_W-1:0]                  num_connections_minus_one,
   output logic                                  physical_layer_program_en,
   output logic                                  router_ready
);

   localparam int NUM_CONN = 2**CONN_ID_W;
   // One extra bit so a connection owning every lane does not wrap to 0.
   localparam int CNT_W = LANE_ID_W + 1;
   localparam logic [LANE_ID_W-1:0] LAST_LANE = LANE_ID_W'(NUM_LANES - 1);

   phy_cfg_state_t state, state_nxt;

   logic [NUM_LANES-1:0]                 sh_en;
   logic [NUM_LANES-1:0][CONN_ID_W-1:0]  sh_conn;
   logic [NUM_CONN-1:0][CNT_W-1:0]       cnt;
   logic [NUM_LANES-1:0][CONN_ID_W-1:0]  work_conn;
   logic [NUM_LANES-1:0][LANE_ID_W-1:0]  work_order;
   logic [NUM_LANES-1:0][LANE_ID_W-1:0]  list_count;
   logic [CONN_ID_W-1:0]                 maxc;
   logic [LANE_ID_W-1:0]                 idx;
   logic [CONN_ID_W-1:0]                 scan_conn;
   logic                                 accept_wr;
   logic                                 accept_commit;
   logic                                 check_fail;
   logic                                 load_table;

   // ---------------------------------------------------------------- handshake
   assign cfg.cfg_ready     = (state == IDLE) || (state == READY) || (state == ERROR);
   assign accept_wr         = cfg.cfg_valid & cfg.cfg_ready & (int'(cfg.cfg_lane) < NUM_LANES);
   assign accept_commit     = cfg.cfg_commit & cfg.cfg_ready;
   assign physical_layer_program_en = (state == PROGRAM);
   assign router_ready      = (state == READY);
   assign scan_conn         = sh_conn[idx];
   assign load_table        = (state == CHECK) && !check_fail;

   // ------------------------------------------------------------ CHECK datapath
   // NOTE: every signal written in an always_comb gets a default before any
   // conditional assignment so no latch is inferred.
   always_comb begin
      list_count = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (sh_en[i]) list_count[i] = LANE_ID_W'(cnt[sh_conn[i]] - 1'b1);
      end
   end

`ifdef PHY_LANE_CFG_CHECK_EN
   // Reject an empty table, or any gap in connection IDs 0..maxc.
   always_comb begin
      check_fail = ~|sh_en;
      for (int c = 0; c < NUM_CONN; c++) begin
         if ((CONN_ID_W'(c) <= maxc) && (cnt[c] == '0)) check_fail = 1'b1;
      end
   end
   assign cfg.cfg_error = (state == ERROR);
`else
   assign check_fail    = 1'b0;
   assign cfg.cfg_error = 1'b0;
`endif

   // ------------------------------------------------------------------ FSM
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, READY, ERROR: if (accept_commit) state_nxt = SCAN;
         SCAN:               if (idx == LAST_LANE) state_nxt = CHECK;
         CHECK:              state_nxt = check_fail ? ERROR : PROGRAM;
         PROGRAM:            state_nxt = READY;
         default:            state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------- datapath
   // NOTE: the shadow table is reset too: "all lanes disabled" is the defined
   // power-up contents, so a commit before any write yields a known result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_en                     <= '0;
         sh_conn                   <= '0;
         cnt                       <= '0;
         work_conn                 <= '0;
         work_order                <= '0;
         maxc                      <= '0;
         idx                       <= '0;
         lanes_connection_id       <= '0;
         lanes_order_id            <= '0;
         physical_lane_list_count  <= '0;
         num_connections_minus_one <= '0;
      end else begin
         // A write in the commit cycle lands here and the scan that starts
         // next cycle already sees it.
         if (accept_wr) begin
            sh_en[cfg.cfg_lane]   <= cfg.cfg_lane_en;
            sh_conn[cfg.cfg_lane] <= cfg.cfg_conn_id;
         end

         if (accept_commit) begin
            cnt  <= '0;
            maxc <= '0;
            idx  <= '0;
         end

         if (state == SCAN) begin
            idx <= idx + 1'b1;
            if (sh_en[idx]) begin
               work_conn[idx]  <= scan_conn;
               work_order[idx] <= LANE_ID_W'(cnt[scan_conn]);
               cnt[scan_conn]  <= cnt[scan_conn] + 1'b1;
               if (scan_conn > maxc) maxc <= scan_conn;
            end else begin
               work_conn[idx]  <= '1;
               work_order[idx] <= '0;
            end
         end

         // Outputs move only on the edge entering PROGRAM.
         if (load_table) begin
            lanes_connection_id       <= work_conn;
            lanes_order_id            <= work_order;
            physical_lane_list_count  <= list_count;
            num_connections_minus_one <= LANE_ID_W'(maxc);
         end
      end
   end

endmodule

// File: tb/tb_phy_lane_table_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for phy_lane_table_sequencer. A bench-side model of the
// shadow table predicts each commit's table; predictions are queued when the
// commit is issued and popped when the DUT strobes program_en or raises
// cfg_error. Also checks commit latency, busy-commit dropping, writes in
// READY, and asynchronous reset in the middle of a scan.
// -----------------------------------------------------------------------------
module tb_phy_lane_table_sequencer;
   import NetTypes::*;

   localparam int NL = NUM_SL3_LANES;
   localparam int CW = CONN_ID_WIDTH;
   localparam int LW = LANE_ID_WIDTH;
   localparam int NC = 2**CW;

   typedef struct packed {
      logic                 err;
      logic [NL-1:0][CW-1:0] conn;
      logic [NL-1:0][LW-1:0] order;
      logic [NL-1:0][LW-1:0] lcnt;
      logic [LW-1:0]         nconn;
   } tbl_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NL-1:0][CW-1:0] lanes_connection_id;
   logic [NL-1:0][LW-1:0] lanes_order_id;
   logic [NL-1:0][LW-1:0] physical_lane_list_count;
   logic [LW-1:0]         num_connections_minus_one;
   logic                  physical_layer_program_en;
   logic                  router_ready;

   phy_lane_table_sequencer_if #(.CONN_ID_W(CW), .LANE_ID_W(LW)) bus ();

   phy_lane_table_sequencer #(.NUM_LANES(NL), .CONN_ID_W(CW), .LANE_ID_W(LW)) dut (
      .clk                       (clk),
      .rst                       (rst),
      .cfg                       (bus),
      .lanes_connection_id       (lanes_connection_id),
      .lanes_order_id            (lanes_order_id),
      .physical_lane_list_count  (physical_lane_list_count),
      .num_connections_minus_one (num_connections_minus_one),
      .physical_layer_program_en (physical_layer_program_en),
      .router_ready              (router_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   tbl_t         sb_q[$];
   tbl_t         shown;      // table the outputs should currently hold
   bit           m_en   [NL];
   logic [CW-1:0] m_conn [NL];

   // Independent formulation: order = enabled earlier lanes on the same
   // connection; count = all enabled lanes on that connection.
   function automatic tbl_t model();
      tbl_t t;
      int   mx;
      bit   any;
      bit   used [NC];
      t   = '0;
      mx  = 0;
      any = 0;
      for (int c = 0; c < NC; c++) used[c] = 0;
      for (int i = 0; i < NL; i++) begin
         int ord;
         int tot;
         if (!m_en[i]) begin
            t.conn[i] = '1;
            continue;
         end
         ord = 0;
         tot = 0;
         for (int j = 0; j < NL; j++) begin
            if (m_en[j] && (m_conn[j] == m_conn[i])) begin
               tot++;
               if (j < i) ord++;
            end
         end
         t.conn[i]  = m_conn[i];
         t.order[i] = LW'(ord);
         t.lcnt[i]  = LW'(tot - 1);
         any        = 1;
         used[m_conn[i]] = 1;
         if (int'(m_conn[i]) > mx) mx = int'(m_conn[i]);
      end
      t.nconn = LW'(mx);
`ifdef PHY_LANE_CFG_CHECK_EN
      t.err = !any;
      for (int c = 0; c <= mx; c++) if (!used[c]) t.err = 1;
`endif
      return t;
   endfunction

   function automatic tbl_t cur_tbl();
      tbl_t t;
      t       = '0;
      t.conn  = lanes_connection_id;
      t.order = lanes_order_id;
      t.lcnt  = physical_lane_list_count;
      t.nconn = num_connections_minus_one;
      return t;
   endfunction

   function automatic bit tbl_differs(input tbl_t a, input tbl_t b);
      return (a.conn !== b.conn) || (a.order !== b.order) ||
             (a.lcnt !== b.lcnt) || (a.nconn !== b.nconn);
   endfunction

   // Present one write on the bus (does not advance time).
   task automatic set_write(input int lane, input int conn, input bit en);
      bus.cfg_valid   = 1'b1;
      bus.cfg_lane    = LW'(lane);
      bus.cfg_conn_id = CW'(conn);
      bus.cfg_lane_en = en;
      if (lane < NL) begin
         m_en[lane]   = en;
         m_conn[lane] = CW'(conn);
      end
   endtask

   task automatic write_lane(input int lane, input int conn, input bit en);
      set_write(lane, conn, en);
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
   endtask

   // Issue a commit (with any write already on the bus) at cycle T and watch
   // T+1..T+12. Optionally re-assert commit during SCAN at T+2.
   task automatic run_commit(input string name, input bit extra_commit);
      tbl_t e;
      tbl_t got;
      int   pe_cyc = -1;
      int   pe_n   = 0;
      int   rdy_cyc = -1;
      int   err_cyc = -1;
      bit   busy_ready = 0;
      e = model();
      sb_q.push_back(e);
      bus.cfg_commit = 1'b1;
      @(posedge clk); #1;
      bus.cfg_commit = 1'b0;
      bus.cfg_valid  = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         bus.cfg_commit = extra_commit && (k == 2);
         if (physical_layer_program_en) begin
            pe_n++;
            if (pe_cyc < 0) begin
               pe_cyc = k;
               if (sb_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL %s_sb_empty: program_en with no expected table", name);
               end else begin
                  tbl_t x;
                  x = sb_q.pop_front();
                  got = cur_tbl();
                  checks++;
                  if (x.err !== 1'b0 || tbl_differs(got, x)) begin
                     errors++;
                     $display("FAIL %s_table: got %h expected %h (exp_err %0b)",
                              name, got, x, x.err);
                  end
                  shown = x;
                  shown.err = 1'b0;
               end
            end
         end
         if (bus.cfg_error && err_cyc < 0) begin
            err_cyc = k;
            if (sb_q.size() != 0) begin
               tbl_t x;
               x = sb_q.pop_front();
               checks++;
               if (x.err !== 1'b1) begin
                  errors++;
                  $display("FAIL %s_unexpected_error: got cfg_error 1 expected 0", name);
               end
            end
         end
         if (router_ready && rdy_cyc < 0) rdy_cyc = k;
         if (k <= (e.err ? NL + 1 : NL + 2) && bus.cfg_ready) busy_ready = 1;
         @(posedge clk); #1;
      end
      bus.cfg_commit = 1'b0;

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL %s_sb_left: got %0d pending expected 0", name, sb_q.size());
         sb_q.delete();
      end
      checks++;
      if (busy_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_cfg_ready_busy: got 1 expected 0 while busy", name);
      end
      if (e.err) begin
         checks++;
         if (err_cyc != NL + 2) begin
            errors++;
            $display("FAIL %s_err_cycle: got %0d expected %0d", name, err_cyc, NL + 2);
         end
         checks++;
         if (pe_n != 0 || rdy_cyc != -1) begin
            errors++;
            $display("FAIL %s_err_no_program: got pulses %0d ready_cyc %0d expected 0 -1",
                     name, pe_n, rdy_cyc);
         end
      end else begin
         checks++;
         if (pe_cyc != NL + 2 || pe_n != 1) begin
            errors++;
            $display("FAIL %s_program_en: got cycle %0d pulses %0d expected cycle %0d pulses 1",
                     name, pe_cyc, pe_n, NL + 2);
         end
         checks++;
         if (rdy_cyc != NL + 3) begin
            errors++;
            $display("FAIL %s_ready_cycle: got %0d expected %0d", name, rdy_cyc, NL + 3);
         end
         checks++;
         if (err_cyc != -1) begin
            errors++;
            $display("FAIL %s_error_raised: got cycle %0d expected none", name, err_cyc);
         end
      end
      got = cur_tbl();
      checks++;
      if (tbl_differs(got, shown)) begin
         errors++;
         $display("FAIL %s_table_held: got %h expected %h", name, got, shown);
      end
   endtask

   task automatic test_reset();
      tbl_t got;
      rst = 1'b1;
      bus.cfg_valid = 1'b0; bus.cfg_commit = 1'b0;
      bus.cfg_lane = '0; bus.cfg_conn_id = '0; bus.cfg_lane_en = 1'b0;
      for (int i = 0; i < NL; i++) begin m_en[i] = 0; m_conn[i] = '0; end
      shown = '0;
      repeat (3) @(posedge clk);
      #1;
      got = cur_tbl();
      checks++;
      if (tbl_differs(got, '0)) begin
         errors++; $display("FAIL reset_table: got %h expected 0", got);
      end
      checks++;
      if ({physical_layer_program_en, router_ready, bus.cfg_error, bus.cfg_ready} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_flags: got pe/rdy/err/cfg_ready %b expected 0001",
                  {physical_layer_program_en, router_ready, bus.cfg_error, bus.cfg_ready});
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_conn();
      for (int i = 0; i < NL; i++) write_lane(i, 0, 1'b1);
      run_commit("single_conn", 1'b0);
   endtask

   task automatic test_two_conn();
      write_lane(0, 0, 1'b1); write_lane(1, 0, 1'b1);
      write_lane(2, 1, 1'b1); write_lane(3, 1, 1'b1);
      run_commit("two_conn", 1'b0);
   endtask

   task automatic test_disabled_lane();
      write_lane(0, 0, 1'b1); write_lane(1, 1, 1'b1);
      write_lane(2, 0, 1'b1);
      // Last lane's disable rides on the commit cycle itself.
      set_write(3, 2, 1'b0);
      run_commit("disabled_lane", 1'b0);
   endtask

   task automatic test_noncontig();
      write_lane(0, 0, 1'b1); write_lane(1, 0, 1'b1);
      write_lane(2, 2, 1'b1); write_lane(3, 2, 1'b1);
      run_commit("noncontig", 1'b0);
   endtask

   task automatic test_empty();
      for (int i = 0; i < NL; i++) write_lane(i, 1, 1'b0);
      run_commit("empty", 1'b0);
   endtask

   task automatic test_back_to_back();
      write_lane(0, 1, 1'b1); write_lane(1, 0, 1'b1);
      write_lane(2, 1, 1'b1); write_lane(3, 0, 1'b1);
      run_commit("busy_commit", 1'b1);
   endtask

   task automatic test_ready_writes();
      tbl_t got;
      write_lane(0, 3, 1'b0);
      write_lane(2, 3, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      got = cur_tbl();
      checks++;
      if (tbl_differs(got, shown) || router_ready !== 1'b1 || physical_layer_program_en !== 1'b0) begin
         errors++;
         $display("FAIL ready_writes: got %h rdy %b pe %b expected %h rdy 1 pe 0",
                  got, router_ready, physical_layer_program_en, shown);
      end
   endtask

   task automatic test_reset_mid();
      tbl_t got;
      int   pe_n = 0;
      bus.cfg_commit = 1'b1;
      @(posedge clk); #1;           // cycle T+1
      bus.cfg_commit = 1'b0;
      repeat (2) @(posedge clk);    // cycle T+3
      #3;
      rst = 1'b1;
      #1;
      for (int i = 0; i < NL; i++) begin m_en[i] = 0; m_conn[i] = '0; end
      shown = '0;
      got = cur_tbl();
      checks++;
      if (tbl_differs(got, '0) || physical_layer_program_en !== 1'b0 || router_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got %h pe %b rdy %b expected 0 0 0",
                  got, physical_layer_program_en, router_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (physical_layer_program_en) pe_n++;
         @(posedge clk); #1;
      end
      checks++;
      if (pe_n != 0 || bus.cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_after: got pulses %0d cfg_ready %b expected 0 1",
                  pe_n, bus.cfg_ready);
      end
   endtask

   initial begin
      test_reset();
      test_single_conn();
      test_two_conn();
      test_disabled_lane();
      test_noncontig();
      test_two_conn();
      test_back_to_back();
      test_ready_writes();
      test_empty();
      test_single_conn();
      test_reset_mid();
      test_two_conn();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
